// File: rtl/bcd_timer_counter_n_if.sv
// Pin bundle for the BCD timer/counter: button/control inputs and display/status outputs.
// The master drives the controls; the slave is the timer itself.
interface bcd_timer_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  inv;
    logic                  mode_btn;
    logic                  start_btn;
    logic                  stop_btn;
    logic                  dir;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [7:0]            segment;
    logic [DIGITS-1:0]     digit;
    logic                  running;
    logic                  done;
    logic                  wrap;

    modport master (
        output inv, mode_btn, start_btn, stop_btn, dir, load, load_val,
        input  count_bcd, segment, digit, running, done, wrap
    );

    modport slave (
        input  inv, mode_btn, start_btn, stop_btn, dir, load, load_val,
        output count_bcd, segment, digit, running, done, wrap
    );
endinterface

// File: rtl/bcd_timer_counter_n.sv
// N-digit synchronous BCD timer/counter with debounced buttons, up/down stepping,
// preload, countdown-done and a multiplexed 7-segment display with blink and polarity control.
module bcd_timer_counter_n #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 1000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_DIV = 1,
    parameter int DEB_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_timer_counter_n_if.slave  bus
);
    localparam int CW     = 4 * DIGITS;
    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int HALF   = CLK_HZ / (2 * TICK_HZ);
    localparam int DIV_W  = (PERIOD > 1)   ? $clog2(PERIOD)   : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
    localparam int DEB_W  = (DEB_LEN > 1)  ? $clog2(DEB_LEN)  : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] val, input logic down);
        logic [CW-1:0] res;
        logic          carry;
        logic [3:0]    nib;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = val[4*i +: 4];
            if (carry && down) begin
                res[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
                carry         = (nib == 4'd0);
            end else if (carry) begin
                res[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
                carry         = (nib == 4'd9);
            end else begin
                res[4*i +: 4] = nib;
            end
        end
        return res;
    endfunction

    function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] val);
        logic [CW-1:0] res;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (val[4*i +: 4] > 4'd9) ? 4'd9 : val[4*i +: 4];
        end
        return res;
    endfunction

    function automatic logic bcd_all_nines(input logic [CW-1:0] val);
        logic res;
        res = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            res = res & (val[4*i +: 4] == 4'd9);
        end
        return res;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] nib);
        case (nib)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // index 0 = start, 1 = stop, 2 = mode
    logic [2:0]       btn_raw_s;
    logic [2:0]       sync1_r, sync2_r, deb_r, rise_r;
    logic [DEB_W-1:0] deb_cnt_r [3];

    state_t           state_r, state_n;
    logic [CW-1:0]    count_r, count_n;
    logic             mode_r, mode_n;
    logic             wrap_r, wrap_n;
    logic             running_r, done_r;
    logic             enter_run_s;

    logic [DIV_W-1:0] div_r;
    logic             phase_r;
    logic             tick_s;

    logic [SCAN_W-1:0] scan_cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [3:0]        nib_s;
    logic              blank_s;
    logic [7:0]        seg_raw_r;
    logic [DIGITS-1:0] dig_raw_r;

    logic [CW-1:0]    stepped_s;
    logic             wrap_s;

    assign btn_raw_s = {bus.mode_btn, bus.stop_btn, bus.start_btn};
    assign stepped_s = bcd_step(count_r, bus.dir);
    assign wrap_s    = bus.dir ? (count_r == '0) : bcd_all_nines(count_r);
    assign tick_s    = (div_r == DIV_W'(PERIOD - 1));

    // Button synchroniser, debounce and one-cycle rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            deb_r   <= 3'b000;
            rise_r  <= 3'b000;
            for (int i = 0; i < 3; i++) deb_cnt_r[i] <= '0;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                rise_r[i] <= 1'b0;
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_W'(DEB_LEN - 1)) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= '0;
                    rise_r[i]    <= sync2_r[i];
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_n;
    end

    // Next state, count, mode and wrap; stop > start > mode > load each cycle.
    always_comb begin
        state_n     = state_r;
        count_n     = count_r;
        mode_n      = mode_r;
        wrap_n      = 1'b0;
        enter_run_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_r[1]) begin
                    state_n = IDLE;
                end else if (rise_r[0] && mode_r) begin
                    state_n     = RUN;
                    enter_run_s = 1'b1;
                end else if (rise_r[0]) begin
                    count_n = stepped_s;
                    wrap_n  = wrap_s;
                end else if (rise_r[2]) begin
                    mode_n = ~mode_r;
                end else if (bus.load) begin
                    count_n = bcd_clamp(bus.load_val);
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (rise_r[1]) begin
                    state_n = PAUSE;
                end else if (tick_s && bus.dir && (count_r == '0)) begin
                    state_n = DONE;
                end else if (tick_s) begin
                    count_n = stepped_s;
                    wrap_n  = wrap_s;
                    state_n = (bus.dir && (stepped_s == '0)) ? DONE : RUN;
                end else begin
                    state_n = RUN;
                end
            end
            PAUSE: begin
                if (rise_r[1]) begin
                    state_n = IDLE;
                end else if (rise_r[0]) begin
                    state_n     = RUN;
                    enter_run_s = 1'b1;
                end else if (bus.load) begin
                    count_n = bcd_clamp(bus.load_val);
                end else begin
                    state_n = PAUSE;
                end
            end
            DONE: begin
                if (rise_r[1] || rise_r[0]) begin
                    state_n = IDLE;
                end else if (bus.load) begin
                    count_n = bcd_clamp(bus.load_val);
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Count, mode and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= '0;
            mode_r    <= 1'b0;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            count_r   <= count_n;
            mode_r    <= mode_n;
            wrap_r    <= wrap_n;
            running_r <= (state_n == RUN);
            done_r    <= (state_n == DONE);
        end
    end

    // Tick divider and blink phase; restarted on every entry to RUN so the first step is a full period away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (enter_run_s) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (tick_s) begin
            div_r   <= '0;
            phase_r <= ~phase_r;
        end else begin
            div_r   <= div_r + DIV_W'(1);
            phase_r <= (div_r == DIV_W'(HALF - 1)) ? ~phase_r : phase_r;
        end
    end

    assign nib_s   = 4'(count_r >> {idx_r, 2'b00});
    assign blank_s = ((state_r == PAUSE) || (state_r == DONE)) && !phase_r;

    // Display scan: digit enable and segment pattern registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r <= '0;
            idx_r      <= '0;
            seg_raw_r  <= 8'h3F;
            dig_raw_r  <= DIGITS'(1);
        end else begin
            if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt_r <= '0;
                idx_r      <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
            end else begin
                scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            end
            seg_raw_r <= blank_s ? 8'h00 : seg7(nib_s);
            dig_raw_r <= DIGITS'(1) << idx_r;
        end
    end

    assign bus.count_bcd = count_r;
    assign bus.segment   = seg_raw_r ^ {8{bus.inv}};
    assign bus.digit     = dig_raw_r ^ {DIGITS{bus.inv}};
    assign bus.running   = running_r;
    assign bus.done      = done_r;
    assign bus.wrap      = wrap_r;
endmodule
